regfile_clr: RTL and testbench

//  Three-port register file: two combinational reads, one synchronous write.
//  It is the responder side of the we3/ra1/ra2/wa3/wd3 -> rd1/rd2 interface that
//  the datapath and the self-checking benches drive.

---
 rtl/regfile_clr.sv | 50 +++++
 tb/tb_regfile_clr.sv | 127 ++++++++++++
 2 files changed

// File: rtl/regfile_clr.sv
// regfile_clr: 2-read/1-write register file with a self-clearing sequencer and hardwired r0
module regfile_clr #(
  parameter int WIDTH = 32,
  parameter int AW = 5,
  parameter int BYPASS = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr_req,
  input  logic             we3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy
);
  localparam int NREGS = 2**AW;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [AW-1:0] clr_ptr, clr_ptr_nx;
  logic [WIDTH-1:0] mem [NREGS];
  logic last;
  assign busy = (state == CLEAR);
  assign last = &clr_ptr;
  // State register: reset always restarts a full clear walk from entry 1
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= CLEAR;
      clr_ptr <= AW'(1);
    end else begin
      state <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  // Next state: walk to the top entry then go ready; a request while ready restarts the walk
  always_comb begin
    state_nx = busy ? (last ? READY : CLEAR) : (clr_req ? CLEAR : READY);
    clr_ptr_nx = busy ? (last ? clr_ptr : clr_ptr + AW'(1)) : (clr_req ? AW'(1) : clr_ptr);
  end
  // Storage has no reset; the walk zeroes it, and entry 0 is never written nor read
  always_ff @(posedge clock)
    if (busy) mem[clr_ptr] <= '0;
    else if (we3 && wa3 != '0) mem[wa3] <= wd3;
  // Reads: zero while clearing or for r0, optional same-cycle forwarding of the write
  always_comb begin
    rd1 = (busy || ra1 == '0) ? '0 : (BYPASS != 0 && we3 && wa3 == ra1) ? wd3 : mem[ra1];
    rd2 = (busy || ra2 == '0) ? '0 : (BYPASS != 0 && we3 && wa3 == ra2) ? wd3 : mem[ra2];
  end
endmodule

// File: tb/tb_regfile_clr.sv
// tb_regfile_clr: table-driven and randomized checks of regfile_clr against a behavioural model
module tb_regfile_clr;
  logic clock = 0, reset_n = 1, clr_req = 0, we3 = 0;
  logic [4:0] ra1 = 0, ra2 = 0, wa3 = 0;
  logic [31:0] wd3 = 0;
  logic [31:0] rd1, rd2, rd1b, rd2b;
  logic busy, busyb;
  int tests = 0, fails = 0;
  logic [31:0] mem_m [32];
  int clr_left = 31;
  logic [31:0] last_rd1, last_rd2, last_rd1b;
  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd; logic [4:0] a1, a2;
    logic [31:0] e1, e2, e1b;
  } vec_t;
  vec_t tbl [9];

  regfile_clr #(.WIDTH(32), .AW(5), .BYPASS(0)) dut (
    .clock(clock), .reset_n(reset_n), .clr_req(clr_req), .we3(we3),
    .ra1(ra1), .ra2(ra2), .wa3(wa3), .wd3(wd3), .rd1(rd1), .rd2(rd2), .busy(busy));
  regfile_clr #(.WIDTH(32), .AW(5), .BYPASS(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .clr_req(clr_req), .we3(we3),
    .ra1(ra1), .ra2(ra2), .wa3(wa3), .wd3(wd3), .rd1(rd1b), .rd2(rd2b), .busy(busyb));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (clr_left > 0 || a == 0) return 0;
    if (byp && we3 && wa3 == a) return wd3;
    return mem_m[a];
  endfunction

  task automatic step(input logic req, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    clr_req = req; we3 = we; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2;
    @(negedge clock);
    last_rd1 = rd1; last_rd2 = rd2; last_rd1b = rd1b;
    chk("rd1", rd1, exp_rd(a1, 0));
    chk("rd2", rd2, exp_rd(a2, 0));
    chk("rd1_byp", rd1b, exp_rd(a1, 1));
    chk("rd2_byp", rd2b, exp_rd(a2, 1));
    chk("busy", 32'(busy), 32'(clr_left > 0));
    chk("busy_byp", 32'(busyb), 32'(clr_left > 0));
    @(posedge clock);
    if (!reset_n) clr_left = 31;
    else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) foreach (mem_m[i]) mem_m[i] = 0;
    end else begin
      if (we && wa != 0) mem_m[wa] = wd;
      if (req) clr_left = 31;
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 0;
    clr_left = 31;
    repeat (cycles) step(0, 1, 5'd3, 32'hBAD0BAD0, 5'd3, 5'd4);
    reset_n = 1;
  endtask

  task automatic count_busy(input string nm, input bit wr);
    int n = 0;
    while (busy && n < 100) begin
      step(0, wr, 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      n++;
    end
    chk(nm, n, 31);
  endtask

  task automatic read_all_zero(input string nm);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 5'(i), 5'(31 - i));
      chk(nm, last_rd1, 0);
      chk(nm, last_rd2, 0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  32'h0,        32'h0,        32'h0};
    tbl[4] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 32'h12345678};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678};
    tbl[6] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'h0,        32'h0,        32'hA5A5A5A5};
    tbl[7] = '{1'b1, 5'd31, 32'h5A5A5A5A, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h5A5A5A5A};
    tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'h5A5A5A5A, 32'h12345678, 32'h5A5A5A5A};
    foreach (mem_m[i]) mem_m[i] = 0;
    #1;
    do_reset(2);
    count_busy("reset_busy_len", 1);
    read_all_zero("reset_clear");
    foreach (tbl[i]) begin
      step(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2);
      chk($sformatf("tbl%0d_rd1", i), last_rd1, tbl[i].e1);
      chk($sformatf("tbl%0d_rd2", i), last_rd2, tbl[i].e2);
      chk($sformatf("tbl%0d_rd1_byp", i), last_rd1b, tbl[i].e1b);
    end
    for (int i = 1; i < 32; i++) step(0, 1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(32 - i));
    step(0, 0, 0, 0, 5'd17, 5'd31);
    chk("fill_r17", last_rd1, 32'h111);
    chk("fill_r31", last_rd2, 32'h11F);
    step(1, 1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd1);
    count_busy("req_busy_len", 1);
    read_all_zero("req_clear");
    step(1, 0, 0, 0, 5'd2, 5'd3);
    repeat (9) step(1, 1, 5'd4, 32'h44444444, 5'd4, 5'd0);
    do_reset(2);
    count_busy("midclr_busy_len", 0);
    read_all_zero("midclr_clear");
    for (int i = 0; i < 300; i++)
      step(5'($urandom_range(0, 39)) == 0, 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
